multi_clock_generator: RTL
==========================

Name: multi_clock_generator

Overview:
- Multi-channel successor to the single down-counter clock generator. Produces CHANNELS independent 50% duty-cycle clocks, such as CNC axis step clocks.
- Each channel adds:
  - double-buffered divisor reload, applied only at period boundaries, so there are no glitches or short periods;
  - an optional burst mode that emits exactly N periods, then stops and flags done.
- Sits between the host register interface and the step/direction output stage.

Parameters:
WIDTH, 32, bit width of divisor, counter and burst count
CHANNELS, 4, number of independent clock channels
CHAN_BITS, 2, width of write_chan; must satisfy 2**CHAN_BITS >= CHANNELS

Ports:
clock_in  input  1  system clock
reset_n  input  1  asynchronous active-low reset
en  input  CHANNELS  per-channel run enable
write  input  1  register write strobe, single clock_in cycle
write_chan  input  CHAN_BITS  target channel of write
write_sel  input  1  0 = divisor shadow, 1 = burst count
write_data  input  WIDTH  value written
clock_out  output  CHANNELS  generated clocks
busy  output  CHANNELS  1 while channel is in HIGH or LOW state
done  output  CHANNELS  one-cycle pulse when a burst completes

Behaviour:
- Reset (reset_n = 0, asynchronous, no clock edge required):
  - clock_out, busy, done = 0;
  - all per-channel registers (shadow, active, count, burst, remaining) = 0;
  - all channels go to IDLE.
- Write: on a clock_in edge with write = 1, write_data goes to shadow[write_chan] (write_sel = 0) or burst[write_chan] (write_sel = 1). Writes with write_chan >= CHANNELS are ignored.
- Timing with divisor D: high phase = D+1 cycles, low phase = D+1 cycles, period = 2*(D+1) cycles. D = 0 gives clock_in/2.
- Per-channel FSM: IDLE, HIGH, LOW, DONE.
  - IDLE:
    - clock_out = 0; active <= shadow every cycle.
    - If en = 1: next cycle HIGH, clock_out = 1, count <= shadow, active <= shadow, remaining <= burst.
  - HIGH:
    - If en = 0: freeze count and clock_out.
    - Else if count != 0: decrement.
    - Else: clock_out <= 0, count <= active, go to LOW.
  - LOW (end of period occurs when count = 0 with en = 1):
    - If en = 0: freeze count and clock_out.
    - Else if count != 0: decrement.
    - Else if remaining = 1: go to DONE; clock_out stays 0; done pulses 1 for one cycle; remaining <= 0.
    - Else: go to HIGH; clock_out <= 1; active <= shadow and count <= shadow (new divisor takes effect here only); if remaining != 0, remaining <= remaining - 1.
  - DONE:
    - clock_out = 0; busy = 0.
    - Go to IDLE when en = 0, or on a write to this channel with write_sel = 1.
- Burst mode: burst = 0 means continuous. burst = N > 0 gives exactly N rising edges, then DONE.
- Simultaneous write and shadow transfer in the same cycle: the transfer uses the old shadow; the new value applies at the next boundary.
- Writing burst while running affects only the next start. Remaining for the current run is unchanged.
- Channels are fully independent. Channels enabled in the same cycle start in the same cycle and stay phase-aligned if their divisors are equal.
- busy = 1 exactly in HIGH and LOW.
- clock_out, busy and done are registered outputs.

Test Plan:
- Reset then write ch0 divisor = 3, burst = 0, en[0] = 1 -> clock_out[0] rises 1 cycle after en; repeating pattern is 4 cycles high, 4 cycles low; busy[0] = 1; other channels stay 0.
- ch1 divisor = 1, burst = 2, en[1] = 1 -> exactly 2 periods of 4 cycles. done[1] pulses once, 8 cycles after the first rising edge. The channel then stays in DONE with clock_out[1] = 0 and busy[1] = 0 while en stays 1. Writing burst = 1 returns it to IDLE and restarts it for 1 period.
- ch0 running with D = 3; write divisor = 0 mid-high-phase -> current period completes at 4/4; next period is 1 high / 1 low; no phase shorter than 1 cycle.
- en[2] dropped for 5 cycles mid-low-phase with D = 2 -> clock_out[2] and count hold; phase resumes with remaining cycles (total low phase = 3 active cycles + 5 stalled cycles).
- Async reset: pull reset_n low mid-run, between clock edges -> clock_out, busy, done = 0 immediately. After release with en held at 1, the channel restarts from IDLE with shadow = 0, i.e. toggles every cycle.
- write_chan = 5 with CHANNELS = 4 and CHAN_BITS = 3 -> no register changes; all outputs unchanged.

Source files
------------

// File: rtl/multi_clock_generator.sv
// Multi-channel 50% duty clock generator with shadowed divisor reload and optional N-period bursts.
// Registered outputs: clock_out rises one clock_in after en; no backpressure, host writes always land.
module multi_clock_generator #(
  parameter int WIDTH     = 32,
  parameter int CHANNELS  = 4,
  parameter int CHAN_BITS = 2
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic [CHANNELS-1:0]  en,
  input  logic                 write,
  input  logic [CHAN_BITS-1:0] write_chan,
  input  logic                 write_sel,
  input  logic [WIDTH-1:0]     write_data,
  output logic [CHANNELS-1:0]  clock_out,
  output logic [CHANNELS-1:0]  busy,
  output logic [CHANNELS-1:0]  done
);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_DONE} state_t;

  typedef struct packed {
    state_t           state;
    logic             clk;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] active;
    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] burst;
    logic [WIDTH-1:0] shadow;
  } chan_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    // Out-of-range write_chan values never match any ID, so such writes are dropped.
    localparam logic [CHAN_BITS-1:0] ID = CHAN_BITS'(i);

    chan_t ch_q;
    chan_t ch_d;
    logic  hit;
    logic  wr_shadow;
    logic  wr_burst;

    assign hit       = write && (write_chan == ID);
    assign wr_shadow = hit && !write_sel;
    assign wr_burst  = hit && write_sel;

    always_comb begin
      ch_d      = ch_q;
      ch_d.done = 1'b0;
      // Register writes land after this cycle, so any reload below still sees the old shadow.
      if (wr_shadow) ch_d.shadow = write_data;
      if (wr_burst)  ch_d.burst  = write_data;

      case (ch_q.state)
        ST_IDLE: begin
          ch_d.clk    = 1'b0;
          ch_d.active = ch_q.shadow;
          if (en[i]) begin
            ch_d.state     = ST_HIGH;
            ch_d.clk       = 1'b1;
            ch_d.count     = ch_q.shadow;
            ch_d.remaining = ch_q.burst;
          end
        end
        ST_HIGH: begin
          if (en[i]) begin
            if (ch_q.count != '0) begin
              ch_d.count = ch_q.count - WIDTH'(1);
            end else begin
              ch_d.state = ST_LOW;
              ch_d.clk   = 1'b0;
              ch_d.count = ch_q.active;
            end
          end
        end
        ST_LOW: begin
          if (en[i]) begin
            if (ch_q.count != '0) begin
              ch_d.count = ch_q.count - WIDTH'(1);
            end else if (ch_q.remaining == WIDTH'(1)) begin
              ch_d.state     = ST_DONE;
              ch_d.clk       = 1'b0;
              ch_d.done      = 1'b1;
              ch_d.remaining = '0;
            end else begin
              // Period boundary: the only point where a new divisor is adopted.
              ch_d.state  = ST_HIGH;
              ch_d.clk    = 1'b1;
              ch_d.active = ch_q.shadow;
              ch_d.count  = ch_q.shadow;
              if (ch_q.remaining != '0) ch_d.remaining = ch_q.remaining - WIDTH'(1);
            end
          end
        end
        ST_DONE: begin
          ch_d.clk = 1'b0;
          if (!en[i] || wr_burst) ch_d.state = ST_IDLE;
        end
        default: begin
          ch_d.state = ST_IDLE;
          ch_d.clk   = 1'b0;
        end
      endcase

      ch_d.busy = (ch_d.state == ST_HIGH) || (ch_d.state == ST_LOW);
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) ch_q <= '0;
      else          ch_q <= ch_d;
    end

    assign clock_out[i] = ch_q.clk;
    assign busy[i]      = ch_q.busy;
    assign done[i]      = ch_q.done;
  end

endmodule
